flag_reg_cond: RTL and testbench

- Architectural NZCV flag register and condition evaluator directly downstream of the ALU flag-select logic.
- Commits the per-instruction flags (neg/zero/carry/ovf with update_flag_reg/update_cv) at the clock edge.
- Evaluates the 2-bit condition code of the next instruction against the committed flags.
- Provides a small LIFO flag stack for interrupt entry/return, plus a direct software flag write.

---
 rtl/flag_pkg.sv | 29 ++
 rtl/flag_stack.sv | 55 +++++
 rtl/flag_reg_cond.sv | 100 ++++++++++
 tb/tb_flag_reg_cond.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/flag_pkg.sv
// rtl/flag_pkg.sv - shared NZCV flag indices, condition codes and flag type
package flag_pkg;

  typedef logic [3:0] flags_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [1:0] COND_AL = 2'b00;
  localparam logic [1:0] COND_EQ = 2'b01;
  localparam logic [1:0] COND_GE = 2'b10;
  localparam logic [1:0] COND_LT = 2'b11;

  function automatic logic cond_eval(input flags_t f, input logic [1:0] cc);
    logic pass;
    pass = 1'b1;
    case (cc)
      COND_AL: pass = 1'b1;
      COND_EQ: pass = f[FLAG_Z];
      COND_GE: pass = (f[FLAG_N] == f[FLAG_V]);
      COND_LT: pass = (f[FLAG_N] != f[FLAG_V]);
      default: pass = 1'b1;
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/flag_stack.sv
// rtl/flag_stack.sv - LIFO of NZCV entries with occupancy count
module flag_stack
  import flag_pkg::*;
#(
  parameter int STACK_DEPTH = 4,
  parameter int CNT_W       = $clog2(STACK_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_ok,
  input  logic             pop_ok,
  input  flags_t           din,
  output flags_t           dout,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(STACK_DEPTH);

  flags_t           mem_q [STACK_DEPTH];
  flags_t           mem_d [STACK_DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] rd_idx;

  // When full the low bits wrap to 0, so wr_idx-1 still names the top entry.
  assign wr_idx = count_q[PTR_W-1:0];
  assign rd_idx = wr_idx - PTR_W'(1);
  assign dout   = mem_q[rd_idx];
  assign count  = count_q;

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    if (push_ok) begin
      mem_d[wr_idx] = din;
      count_d       = count_q + CNT_W'(1);
    end else if (pop_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/flag_reg_cond.sv
// rtl/flag_reg_cond.sv - committed NZCV register, condition evaluator and interrupt flag stack
module flag_reg_cond
  import flag_pkg::*;
#(
  parameter int STACK_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          update_flag_reg,
  input  logic                          update_cv,
  input  logic                          neg,
  input  logic                          zero,
  input  logic                          carry,
  input  logic                          ovf,
  input  logic                          flag_wr,
  input  logic [3:0]                    flag_wr_data,
  input  logic                          push,
  input  logic                          pop,
  input  logic [1:0]                    cond_code,
  output logic                          cond_pass,
  output logic [3:0]                    flags_out,
  output logic [$clog2(STACK_DEPTH):0]  stack_count,
  output logic                          stack_full,
  output logic                          stack_empty,
  output logic                          stack_err
);

  localparam int CNT_W = $clog2(STACK_DEPTH) + 1;

  flags_t           flags_q;
  flags_t           flags_d;
  logic             err_q;
  logic             err_d;
  logic             push_ok;
  logic             pop_ok;
  flags_t           stack_dout;
  logic [CNT_W-1:0] count;

  assign stack_count = count;
  assign stack_full  = (count == CNT_W'(STACK_DEPTH));
  assign stack_empty = (count == '0);
  assign stack_err   = err_q;
  assign flags_out   = flags_q;
  assign cond_pass   = cond_eval(flags_q, cond_code);

  // Simultaneous push and pop is treated as an error and neither is honoured.
  assign push_ok = en && push && !pop && !stack_full;
  assign pop_ok  = en && pop && !push && !stack_empty;

  always_comb begin
    err_d = 1'b0;
    if (en) begin
      err_d = (push && pop) || (push && stack_full) || (pop && stack_empty);
    end
  end

  always_comb begin
    flags_d = flags_q;
    if (en) begin
      if (pop_ok) begin
        flags_d = stack_dout;
      end else if (flag_wr) begin
        flags_d = flag_wr_data;
      end else if (update_flag_reg) begin
        flags_d[FLAG_N] = neg;
        flags_d[FLAG_Z] = zero;
        if (update_cv) begin
          flags_d[FLAG_C] = carry;
          flags_d[FLAG_V] = ovf;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  // The stack captures flags_q, i.e. the flags before any same-edge update.
  flag_stack #(
    .STACK_DEPTH (STACK_DEPTH),
    .CNT_W       (CNT_W)
  ) u_flag_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_ok (push_ok),
    .pop_ok  (pop_ok),
    .din     (flags_q),
    .dout    (stack_dout),
    .count   (count)
  );

endmodule

// File: tb/tb_flag_reg_cond.sv
// tb/tb_flag_reg_cond.sv - scoreboard bench for flag_reg_cond
module tb_flag_reg_cond;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       update_flag_reg = 1'b0;
  logic       update_cv = 1'b0;
  logic       neg = 1'b0;
  logic       zero = 1'b0;
  logic       carry = 1'b0;
  logic       ovf = 1'b0;
  logic       flag_wr = 1'b0;
  logic [3:0] flag_wr_data = 4'b0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [1:0] cond_code = 2'b00;
  logic       cond_pass;
  logic [3:0] flags_out;
  logic [2:0] stack_count;
  logic       stack_full;
  logic       stack_empty;
  logic       stack_err;

  typedef struct {
    int         id;
    logic [3:0] flags;
    int         count;
    logic       err;
    logic       pass;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  flag_reg_cond #(.STACK_DEPTH(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en              (en),
    .update_flag_reg (update_flag_reg),
    .update_cv       (update_cv),
    .neg             (neg),
    .zero            (zero),
    .carry           (carry),
    .ovf             (ovf),
    .flag_wr         (flag_wr),
    .flag_wr_data    (flag_wr_data),
    .push            (push),
    .pop             (pop),
    .cond_code       (cond_code),
    .cond_pass       (cond_pass),
    .flags_out       (flags_out),
    .stack_count     (stack_count),
    .stack_full      (stack_full),
    .stack_empty     (stack_empty),
    .stack_err       (stack_err)
  );

  task automatic check(input int id, input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL v%0d %s: got %0d expected %0d", id, name, act, req);
    end
  endtask

  // Monitor: compares the state held mid-cycle against the queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.id, "flags_out",   int'(flags_out),   int'(e.flags));
      check(e.id, "stack_count", int'(stack_count), e.count);
      check(e.id, "stack_full",  int'(stack_full),  (e.count == 4) ? 1 : 0);
      check(e.id, "stack_empty", int'(stack_empty), (e.count == 0) ? 1 : 0);
      check(e.id, "stack_err",   int'(stack_err),   int'(e.err));
      check(e.id, "cond_pass",   int'(cond_pass),   int'(e.pass));
    end
  end

  int vid = 0;

  // One vector per cycle: drive inputs for the coming edge and queue the
  // state expected during this cycle (result of the previous edge).
  task automatic cyc(input logic r, input logic e, input logic ufr, input logic ucv,
                     input logic [3:0] alu, input logic fw, input logic [3:0] fwd,
                     input logic ps, input logic pp, input logic [1:0] cc,
                     input logic [3:0] ef, input int ec, input logic eerr, input logic epass);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n           = r;
    en              = e;
    update_flag_reg = ufr;
    update_cv       = ucv;
    {neg, zero, carry, ovf} = alu;
    flag_wr         = fw;
    flag_wr_data    = fwd;
    push            = ps;
    pop             = pp;
    cond_code       = cc;
    x.id    = vid;
    x.flags = ef;
    x.count = ec;
    x.err   = eerr;
    x.pass  = epass;
    exp_q.push_back(x);
    vid++;
  endtask

  initial begin
    //   rst en ufr ucv alu     fw fwd     ps pp cc      exp_flags cnt err pass
    cyc(0, 1, 0, 0, 4'b0000, 0, 4'b0000, 0, 0, 2'b00, 4'b0000, 0, 0, 1);
    cyc(1, 1, 1, 1, 4'b1010, 0, 4'b0000, 0, 0, 2'b00, 4'b0000, 0, 0, 1);
    cyc(1, 1, 0, 0, 4'b0000, 0, 4'b0000, 0, 0, 2'b10, 4'b1010, 0, 0, 0);
    cyc(1, 1, 0, 0, 4'b0000, 0, 4'b0000, 0, 0, 2'b11, 4'b1010, 0, 0, 1);
    cyc(1, 1, 1, 0, 4'b0101, 0, 4'b0000, 0, 0, 2'b01, 4'b1010, 0, 0, 0);
    cyc(1, 1, 0, 0, 4'b0000, 0, 4'b0000, 0, 0, 2'b01, 4'b0110, 0, 0, 1);
    cyc(1, 1, 0, 0, 4'b0000, 1, 4'b0100, 0, 0, 2'b00, 4'b0110, 0, 0, 1);
    cyc(1, 1, 0, 0, 4'b0000, 1, 4'b1001, 1, 0, 2'b01, 4'b0100, 0, 0, 1);
    cyc(1, 1, 0, 0, 4'b0000, 0, 4'b0000, 0, 1, 2'b10, 4'b1001, 1, 0, 1);
    cyc(1, 1, 0, 0, 4'b0000, 0, 4'b0000, 0, 0, 2'b11, 4'b0100, 0, 0, 0);
    // fill the stack, then overflow with a fifth push
    cyc(1, 1, 0, 0, 4'b0000, 1, 4'b0001, 1, 0, 2'b00, 4'b0100, 0, 0, 1);
    cyc(1, 1, 0, 0, 4'b0000, 1, 4'b0010, 1, 0, 2'b00, 4'b0001, 1, 0, 1);
    cyc(1, 1, 0, 0, 4'b0000, 1, 4'b0011, 1, 0, 2'b00, 4'b0010, 2, 0, 1);
    cyc(1, 1, 0, 0, 4'b0000, 1, 4'b1000, 1, 0, 2'b00, 4'b0011, 3, 0, 1);
    cyc(1, 1, 0, 0, 4'b0000, 1, 4'b1100, 1, 0, 2'b11, 4'b1000, 4, 0, 1);
    // drain in LIFO order
    cyc(1, 1, 0, 0, 4'b0000, 0, 4'b0000, 0, 1, 2'b00, 4'b1100, 4, 1, 1);
    cyc(1, 1, 0, 0, 4'b0000, 0, 4'b0000, 0, 1, 2'b10, 4'b0011, 3, 0, 0);
    cyc(1, 1, 0, 0, 4'b0000, 0, 4'b0000, 0, 1, 2'b00, 4'b0010, 2, 0, 1);
    cyc(1, 1, 0, 0, 4'b0000, 0, 4'b0000, 0, 1, 2'b11, 4'b0001, 1, 0, 1);
    // pop on empty with ALU update, then push&pop collision
    cyc(1, 1, 1, 0, 4'b1000, 0, 4'b0000, 0, 1, 2'b01, 4'b0100, 0, 0, 1);
    cyc(1, 1, 0, 0, 4'b0000, 0, 4'b0000, 1, 0, 2'b00, 4'b1000, 0, 1, 1);
    cyc(1, 1, 0, 0, 4'b0000, 0, 4'b0000, 1, 1, 2'b00, 4'b1000, 1, 0, 1);
    cyc(1, 1, 0, 0, 4'b0000, 0, 4'b0000, 0, 0, 2'b00, 4'b1000, 1, 1, 1);
    // stall holds everything
    cyc(1, 0, 1, 1, 4'b0111, 0, 4'b0000, 1, 0, 2'b00, 4'b1000, 1, 0, 1);
    cyc(1, 0, 0, 0, 4'b0000, 0, 4'b0000, 1, 1, 2'b00, 4'b1000, 1, 0, 1);
    cyc(1, 1, 0, 0, 4'b0000, 0, 4'b0000, 1, 1, 2'b00, 4'b1000, 1, 0, 1);
    cyc(1, 0, 0, 0, 4'b0000, 0, 4'b0000, 0, 0, 2'b00, 4'b1000, 1, 1, 1);
    cyc(1, 1, 0, 0, 4'b0000, 0, 4'b0000, 0, 0, 2'b00, 4'b1000, 1, 0, 1);
    // build count=3, then asynchronous reset between edges
    cyc(1, 1, 0, 0, 4'b0000, 1, 4'b0111, 1, 0, 2'b00, 4'b1000, 1, 0, 1);
    cyc(1, 1, 0, 0, 4'b0000, 0, 4'b0000, 1, 0, 2'b11, 4'b0111, 2, 0, 1);
    cyc(0, 1, 0, 0, 4'b0000, 0, 4'b0000, 0, 0, 2'b00, 4'b0000, 0, 0, 1);
    cyc(1, 1, 0, 0, 4'b0000, 0, 4'b0000, 0, 0, 2'b00, 4'b0000, 0, 0, 1);
    cyc(1, 1, 0, 0, 4'b0000, 0, 4'b0000, 0, 1, 2'b00, 4'b0000, 0, 0, 1);
    cyc(1, 1, 0, 0, 4'b0000, 0, 4'b0000, 0, 0, 2'b01, 4'b0000, 0, 1, 0);

    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
